mem_request_ctrl: RTL and testbench

- Responder end of the cache-to-memory request interface.
- Accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the cache block, arbitrates them onto a single-ported RAM, and answers each requester with wait/load.
- Sits between the caches block and the RAM. Provides registered responses, data-over-instruction priority, and a timeout watchdog on the RAM handshake.

---
 rtl/mem_request_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_request_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl
// Responder end of the cache-to-memory request interface. Takes instruction
// fetches and data reads/writes from the cache block, arbitrates them onto a
// single-ported RAM (data beats instruction), and answers each requester with
// a one-cycle wait=0 response. A watchdog abandons any RAM access that does
// not complete within TIMEOUT cycles and raises a sticky error flag.
//
// Ports
//   CLK, nRST          clock (rising edge), async active-low reset
//   iREN, iaddr        instruction read request / address
//   dREN, dWEN         data read / write request (both high = write)
//   daddr, dstore      data address / write data
//   iwait, iload       instruction response (iwait=0 for one cycle)
//   dwait, dload       data response (dwait=0 for one cycle)
//   ramREN, ramWEN     RAM strobes (registered)
//   ramaddr, ramstore  RAM address / write data (registered)
//   ramload, ramready  RAM read data / one-cycle completion pulse
//   memerr             sticky timeout flag, cleared only by reset
module mem_request_ctrl #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              memerr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                opWrite_q;
  logic                iwait_q;
  logic                dwait_q;
  logic [WORD_W-1:0]   iload_q;
  logic [WORD_W-1:0]   dload_q;
  logic                ramREN_q;
  logic                ramWEN_q;
  logic [WORD_W-1:0]   ramaddr_q;
  logic [WORD_W-1:0]   ramstore_q;
  logic                memerr_q;

  // Watchdog counter saturates at TIMEOUT-1 rather than wrapping.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Single-process FSM. Every output is a register, so the RAM side and the
  // requester side only ever see clean, glitch-free levels. The latched
  // request lives directly in the RAM address/data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opWrite_q  <= 1'b0;
      iwait_q    <= 1'b1;
      dwait_q    <= 1'b1;
      iload_q    <= '0;
      dload_q    <= '0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      memerr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Data has priority; dREN together with dWEN is a write.
          if (dREN || dWEN) begin
            ramaddr_q  <= daddr;
            ramstore_q <= dstore;
            opWrite_q  <= dWEN;
            ramWEN_q   <= dWEN;
            ramREN_q   <= ~dWEN;
            cnt_q      <= '0;
            state_q    <= DACC;
          end else if (iREN) begin
            ramaddr_q  <= iaddr;
            ramREN_q   <= 1'b1;
            ramWEN_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IACC;
          end
        end

        DACC, IACC: begin
          // A completion in the last allowed cycle still counts as success.
          if (ramready) begin
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            if (state_q == DACC) begin
              if (!opWrite_q) begin
                dload_q <= ramload;
              end
              dwait_q <= 1'b0;
              state_q <= DRESP;
            end else begin
              iload_q <= ramload;
              iwait_q <= 1'b0;
              state_q <= IRESP;
            end
          end else if (cnt_q == CNT_MAX) begin
            // Abandon the access but still release the requester.
            memerr_q <= 1'b1;
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            if (state_q == DACC) begin
              dwait_q <= 1'b0;
              state_q <= DRESP;
            end else begin
              iwait_q <= 1'b0;
              state_q <= IRESP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DRESP: begin
          dwait_q <= 1'b1;
          state_q <= IDLE;
        end

        IRESP: begin
          iwait_q <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Testbench for mem_request_ctrl: directed requests, a behavioural RAM that
// answers after a programmable delay, and a response scoreboard.
module tb_mem_request_ctrl;

  localparam int W  = 32;
  localparam int TO = 64;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [W-1:0]  iaddr;
  logic          dREN;
  logic          dWEN;
  logic [W-1:0]  daddr;
  logic [W-1:0]  dstore;
  logic          iwait;
  logic          dwait;
  logic [W-1:0]  iload;
  logic [W-1:0]  dload;
  logic          ramREN;
  logic          ramWEN;
  logic [W-1:0]  ramaddr;
  logic [W-1:0]  ramstore;
  logic [W-1:0]  ramload;
  logic          ramready;
  logic          memerr;

  mem_request_ctrl #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .memerr(memerr)
  );

  typedef struct {
    bit          isData;
    logic [W-1:0] load;
    logic        err;
  } resp_t;

  resp_t        sbq[$];
  logic [W-1:0] mem [logic [W-1:0]];
  int           checks   = 0;
  int           failures = 0;
  int           ramDelay = 1;
  bit           ramEnable = 1'b1;
  logic [W-1:0] expDload = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] memDefault(logic [W-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(string pfx);
    checkOutput({pfx, "_iwait"},    32'(iwait),  32'd1);
    checkOutput({pfx, "_dwait"},    32'(dwait),  32'd1);
    checkOutput({pfx, "_iload"},    iload,       32'd0);
    checkOutput({pfx, "_dload"},    dload,       32'd0);
    checkOutput({pfx, "_ramREN"},   32'(ramREN), 32'd0);
    checkOutput({pfx, "_ramWEN"},   32'(ramWEN), 32'd0);
    checkOutput({pfx, "_ramaddr"},  ramaddr,     32'd0);
    checkOutput({pfx, "_ramstore"}, ramstore,    32'd0);
    checkOutput({pfx, "_memerr"},   32'(memerr), 32'd0);
  endtask

  // Behavioural RAM: raises ramready in the ramDelay-th cycle a strobe is seen.
  initial begin
    int waitCnt;
    waitCnt  = 0;
    ramready = 1'b0;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #1;
      ramready = 1'b0;
      if ((ramREN || ramWEN) && ramEnable) begin
        waitCnt++;
        if (waitCnt >= ramDelay) begin
          ramready = 1'b1;
          if (ramWEN) begin
            mem[ramaddr] = ramstore;
            ramload = 32'hBAD0_BAD0;
          end else begin
            ramload = mem.exists(ramaddr) ? mem[ramaddr] : memDefault(ramaddr);
          end
          waitCnt = 0;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Response monitor: every wait=0 cycle must match the head of the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        checkOutput("waits_not_both_low", 32'(iwait === 1'b0 && dwait === 1'b0), 32'd0);
        if (iwait === 1'b0 || dwait === 1'b0) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_resp", 32'(sbq.size()), 32'd1);
          end else begin
            e = sbq.pop_front();
            checkOutput("resp_port",   32'(dwait === 1'b0), 32'(e.isData));
            checkOutput("resp_load",   e.isData ? dload : iload, e.load);
            checkOutput("resp_memerr", 32'(memerr), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic applyStimulus(logic i_ren, logic [W-1:0] i_a, logic d_ren,
                               logic d_wen, logic [W-1:0] d_a, logic [W-1:0] d_s);
    iREN = i_ren; iaddr = i_a; dREN = d_ren; dWEN = d_wen; daddr = d_a; dstore = d_s;
  endtask

  task automatic pushResp(bit isData, logic [W-1:0] load, logic err);
    resp_t e;
    e.isData = isData; e.load = load; e.err = err;
    sbq.push_back(e);
  endtask

  // Waits (bounded) for the first ACC cycle and checks the RAM-side outputs.
  task automatic waitAccess(string tag, logic [W-1:0] a, logic ren, logic wen,
                            bit chkStore, logic [W-1:0] s);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) break;
    end
    checkOutput({tag, "_ramaddr"}, ramaddr, a);
    checkOutput({tag, "_ramREN"},  32'(ramREN), 32'(ren));
    checkOutput({tag, "_ramWEN"},  32'(ramWEN), 32'(wen));
    if (chkStore) checkOutput({tag, "_ramstore"}, ramstore, s);
  endtask

  // Waits (bounded) until the scoreboard has drained to n entries.
  task automatic waitQueue(string tag, int n, int bound);
    for (int k = 0; k < bound; k++) begin
      if (sbq.size() <= n) break;
      @(posedge CLK);
      #1;
    end
    checkOutput({tag, "_drained"}, 32'(sbq.size()), 32'(n));
  endtask

  initial begin
    int n;
    nRST = 1'b0;
    applyStimulus(0, '0, 0, 0, '0, '0);
    mem[32'h0000_0040] = 32'h2001_0005;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkResetValues("reset");
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("idle_iwait", 32'(iwait), 32'd1);
    checkOutput("idle_dwait", 32'(dwait), 32'd1);

    // Instruction fetch, RAM answers in the second access cycle.
    ramDelay = 2;
    applyStimulus(1, 32'h0000_0040, 0, 0, '0, '0);
    pushResp(0, 32'h2001_0005, 1'b0);
    waitAccess("ifetch", 32'h40, 1, 0, 0, '0);
    waitQueue("ifetch", 0, 20);
    applyStimulus(0, '0, 0, 0, '0, '0);
    ramDelay = 1;

    // Data write; dload must not pick up the RAM's read bus.
    applyStimulus(0, '0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF);
    pushResp(1, expDload, 1'b0);
    waitAccess("dwrite", 32'h100, 0, 1, 1, 32'hDEAD_BEEF);
    waitQueue("dwrite", 0, 20);
    applyStimulus(0, '0, 0, 0, '0, '0);

    // Simultaneous data read and fetch: data first, then the fetch.
    applyStimulus(1, 32'h0000_0004, 1, 0, 32'h0000_0200, '0);
    pushResp(1, memDefault(32'h200), 1'b0);
    pushResp(0, memDefault(32'h004), 1'b0);
    expDload = memDefault(32'h200);
    waitAccess("prio_data", 32'h200, 1, 0, 0, '0);
    waitQueue("prio_data", 1, 20);
    dREN = 1'b0;
    waitAccess("prio_instr", 32'h04, 1, 0, 0, '0);
    waitQueue("prio_instr", 0, 20);
    applyStimulus(0, '0, 0, 0, '0, '0);

    // dREN and dWEN together is a write.
    applyStimulus(0, '0, 1, 1, 32'h0000_0300, 32'h1234_5678);
    pushResp(1, expDload, 1'b0);
    waitAccess("rw_both", 32'h300, 0, 1, 1, 32'h1234_5678);
    waitQueue("rw_both", 0, 20);
    applyStimulus(0, '0, 0, 0, '0, '0);

    // RAM never answers: watchdog releases the requester after TIMEOUT cycles.
    ramEnable = 1'b0;
    applyStimulus(0, '0, 1, 0, 32'h0000_0100, '0);
    pushResp(1, expDload, 1'b1);
    waitAccess("timeout", 32'h100, 1, 0, 0, '0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      n++;
      if (dwait === 1'b0) break;
    end
    checkOutput("timeout_latency", 32'(n), 32'(TO));
    checkOutput("timeout_ramREN", 32'(ramREN), 32'd0);
    checkOutput("timeout_memerr", 32'(memerr), 32'd1);
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(posedge CLK); #1;
    ramEnable = 1'b1;
    waitQueue("timeout", 0, 5);

    // Successful read after the timeout; memerr stays set, write landed.
    applyStimulus(0, '0, 1, 0, 32'h0000_0100, '0);
    pushResp(1, 32'hDEAD_BEEF, 1'b1);
    expDload = 32'hDEAD_BEEF;
    waitAccess("post_timeout", 32'h100, 1, 0, 0, '0);
    waitQueue("post_timeout", 0, 20);
    applyStimulus(0, '0, 0, 0, '0, '0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("memerr_sticky", 32'(memerr), 32'd1);

    // Reset in the middle of a data access: outputs clear without a clock edge.
    ramEnable = 1'b0;
    applyStimulus(0, '0, 1, 0, 32'h0000_0300, '0);
    waitAccess("mid_reset", 32'h300, 1, 0, 0, '0);
    #2;
    nRST = 1'b0;
    #1;
    checkResetValues("async_reset");
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    ramEnable = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("no_resp_after_reset", 32'(sbq.size()), 32'd0);
    checkOutput("post_reset_dwait", 32'(dwait), 32'd1);
    checkOutput("post_reset_memerr", 32'(memerr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
